// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes in one cycle with an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [W:0]      r_q, r_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    d_q, d_d;
  logic            done_q, done_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [W:0]      t;
  logic [W:0]      diff;
  logic            ge;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    // Shift the next dividend bit into the partial remainder, then try subtracting.
    t       = {r_q[W-1:0], q_q[W-1]};
    ge      = (t >= {1'b0, d_q});
    diff    = t - {1'b0, d_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != '0) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            count_d = CntW'(W - 1);
            state_d = StCalc;
          end else begin
            done_d = 1'b1;
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
          end
        end
      end
      StCalc: begin
        r_d     = ge ? diff : t;
        q_d     = {q_q[W-2:0], ge};
        count_d = count_q - CntW'(1);
        if (count_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d[W-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (W=4): the driver queues expected results,
// and a negedge monitor pops and compares them whenever done is seen.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  seq_divider #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 15; e.r = a; e.dbz = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.dbz);
      end
    end
  end

  // One isolated division: checks busy, latency and that done lasts a single cycle.
  task automatic do_div(input int a, input int b, input bit full);
    int n;
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    if (full) check("busy_after_accept", int'(busy), (b != 0) ? 1 : 0);
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, (b == 0) ? 0 : W);
    if (full) check("busy_at_done", int'(busy), 0);
    @(posedge clk);
    #1 check("done_single_cycle", int'(done), 0);
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;

    do_div(13, 4, 1'b1);
    do_div(7, 0, 1'b1);
    do_div(15, 1, 1'b1);
    do_div(3, 9, 1'b1);
    do_div(0, 5, 1'b1);

    // 14/3 with a stray 9/2 request mid-calculation, then 9/2 issued in the done cycle.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    exp_q.push_back(model(14, 3));
    @(posedge clk);              // accepting edge
    #1 start = 1'b0;
    @(posedge clk);              // first step
    #1 begin start = 1'b1; dividend = 4'd9; divisor = 4'd2; end
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);              // final step, done rises
    #1 check("done_14_3", int'(done), 1);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    exp_q.push_back(model(9, 2));
    @(posedge clk);              // accepted in the done cycle
    #1 begin
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      dividend = 4'd1; divisor = 4'd1;
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("b2b_done_count", dones, 1);

    // Asynchronous reset in the middle of 12/5.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 begin
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_div(a, b, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
